demux_stream: RTL and testbench
===============================

DEMUX_STREAM -- requirements
Module: demux_stream

Interface
Parameters:
- REQ-001 The block SHALL have parameter DATA_W, default 8, giving the payload width in bits.
- REQ-002 The block SHALL have parameter N_CH, default 8, legal range 2..16, giving the number of output channels.
- REQ-003 The block SHALL have parameter SEL_W, default $clog2(N_CH), giving the select width.

Ports:
- REQ-004 clk  in  1  single clock; all state on rising edge.
- REQ-005 rst  in  1  reset, synchronous, active-high.
- REQ-006 in_data  in  DATA_W  payload.
- REQ-007 in_sel  in  SEL_W  destination channel.
- REQ-008 in_valid  in  1  upstream offers a word.
- REQ-009 in_ready  out  1  block accepts the word this cycle.
- REQ-010 out_data  out  N_CH*DATA_W  flat bus; channel k occupies bits [k*DATA_W +: DATA_W].
- REQ-011 out_valid  out  N_CH  per-channel word held.
- REQ-012 out_ready  in  N_CH  per-channel downstream accepts.
- REQ-013 sel_err  out  1  one-cycle pulse after an out-of-range select is accepted.
- REQ-014 xfer_cnt  out  N_CH*16  per-channel accepted-word counters, flat bus, same slicing as out_data.

Function
- REQ-015 Each channel SHALL hold a one-entry register (data plus valid flag).
- REQ-016 A transfer SHALL occur when in_valid && in_ready. At the next edge the word SHALL load into slot in_sel and set its valid flag. Latency is 1 cycle.
- REQ-017 When in_sel < N_CH, in_ready SHALL equal !out_valid[in_sel] || out_ready[in_sel], combinationally, so one word per cycle streams through a slot whose consumer is ready.
- REQ-018 When in_sel >= N_CH, in_ready SHALL be 1, the word SHALL be discarded, and sel_err SHALL be 1 for exactly the following cycle.
- REQ-019 out_valid[k] SHALL clear on out_valid[k] && out_ready[k], unless the same edge reloads slot k. Load takes priority, so the slot stays valid with the new data.
- REQ-020 out_data slice k SHALL be 0 whenever out_valid[k] is 0. Non-selected channels never show stale data.
- REQ-021 A held word SHALL stay stable until consumed. Loads into other channels SHALL NOT disturb it.
- REQ-022 in_ready SHALL NOT depend on out_ready of any channel other than in_sel.
- REQ-023 xfer_cnt slice k SHALL increment by 1 per transfer into slot k and saturate at 16'hFFFF. Dropped out-of-range words SHALL NOT be counted.

Reset
- REQ-024 While rst is 1 at a clock edge, the block SHALL set all out_valid to 0, all out_data to 0, sel_err to 0 and all xfer_cnt to 0.
- REQ-025 A word in flight when rst asserts SHALL be lost. in_ready SHALL follow REQ-017/018 combinationally from the reset state.

Configuration
- REQ-026 The counters SHALL be compiled in only when macro DEMUX_STREAM_CNT_EN is defined.
- REQ-027 With DEMUX_STREAM_CNT_EN defined, xfer_cnt SHALL behave per REQ-023.
- REQ-028 Without DEMUX_STREAM_CNT_EN, xfer_cnt SHALL be tied to 0, no counter flops SHALL exist, and the port list SHALL be unchanged.

Structure
- REQ-029 Package demux_pkg SHALL hold DEMUX_DATA_W_DEF=8, DEMUX_N_CH_DEF=8, DEMUX_CNT_W=16 and the saturating-increment function.
- REQ-030 Per-channel storage SHALL be sub-module demux_stream_slot (ports: clk, rst, load, din, ready, valid, dout, cnt), instantiated N_CH times in a generate loop.

Verification
- REQ-031 Reset: rst=1 for 2 cycles with in_valid=1 -> all out_valid=0, out_data=0, xfer_cnt=0 after release.
- REQ-032 Basic route: in_sel=3, in_data=8'hA5, all out_ready=0 -> next cycle out_valid=8'b0000_1000, slice 3=8'hA5, other slices 0.
- REQ-033 Backpressure: slot 3 full, out_ready[3]=0, second word 8'h5A to sel 3 -> in_ready=0, slot keeps 8'hA5. Raise out_ready[3] -> 8'h5A loads the same edge A5 leaves, and out_valid[3] stays 1.
- REQ-034 Streaming: out_ready=all 1, words 0x00..0x0F to sel=k mod 8 back-to-back -> in_ready constantly 1, each word appears 1 cycle later on the correct slice, each xfer_cnt slice=2.
- REQ-035 Bad select: N_CH=6, in_sel=7, in_valid=1 -> in_ready=1, sel_err pulses 1 cycle, no out_valid change, counters unchanged.
- REQ-036 Saturation (DEMUX_STREAM_CNT_EN): 65 540 transfers to channel 0 -> xfer_cnt slice 0 = 16'hFFFF. Without the macro, the same run gives xfer_cnt=0.

Source files
------------

// File: rtl/demux_pkg.sv
// ============================================================================
// Module   : demux_pkg
// Brief    : Shared defaults, counter type and saturating increment for the
//            demux_stream slice (counters enabled by DEMUX_STREAM_CNT_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none

package demux_pkg;

  localparam int DEMUX_DATA_W_DEF = 8;
  localparam int DEMUX_N_CH_DEF   = 8;
  localparam int DEMUX_CNT_W      = 16;

  typedef logic [DEMUX_CNT_W-1:0] demux_cnt_t;

  // Counters stick at all-ones rather than wrapping back to zero.
  function automatic demux_cnt_t sat_inc(input demux_cnt_t v);
    return (v == '1) ? v : demux_cnt_t'(v + demux_cnt_t'(1));
  endfunction

endpackage : demux_pkg

`default_nettype wire

// File: rtl/demux_stream_slot.sv
// ============================================================================
// Module   : demux_stream_slot
// Brief    : One-entry holding register for a single demux output channel,
//            with an optional saturating transfer counter (DEMUX_STREAM_CNT_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none

module demux_stream_slot
  import demux_pkg::*;
#(
  parameter int DATA_W = DEMUX_DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] dout,
  output demux_cnt_t        cnt
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;

  // A load on the same edge as a consume wins, so the slot stays full.
  // The data register is zeroed when the slot empties, keeping idle outputs at 0.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = din;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
      data_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign dout  = data_q;

`ifdef DEMUX_STREAM_CNT_EN
  demux_cnt_t cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
`else
  assign cnt = '0;
`endif

endmodule : demux_stream_slot

`default_nettype wire

// File: rtl/demux_stream.sv
// ============================================================================
// Module   : demux_stream
// Brief    : Routes a valid/ready input stream to one of N_CH one-entry output
//            slots; out-of-range selects are dropped and flagged on sel_err.
//            Per-channel transfer counters exist only with DEMUX_STREAM_CNT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module demux_stream
  import demux_pkg::*;
#(
  parameter int DATA_W = DEMUX_DATA_W_DEF,
  parameter int N_CH   = DEMUX_N_CH_DEF,
  parameter int SEL_W  = $clog2(N_CH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_W-1:0]           in_data,
  input  logic [SEL_W-1:0]            in_sel,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [N_CH*DATA_W-1:0]      out_data,
  output logic [N_CH-1:0]             out_valid,
  input  logic [N_CH-1:0]             out_ready,
  output logic                        sel_err,
  output logic [N_CH*DEMUX_CNT_W-1:0] xfer_cnt
);

  logic [N_CH-1:0] sel_hit;
  logic            sel_ok;
  logic            slot_ready;
  logic [N_CH-1:0] load;
  logic            sel_err_q, sel_err_d;

  // Only the addressed channel's state feeds in_ready; a select that matches
  // no channel leaves slot_ready at 1 so the word is swallowed.
  always_comb begin
    sel_hit    = '0;
    slot_ready = 1'b1;
    for (int k = 0; k < N_CH; k++) begin
      if (in_sel == SEL_W'(k)) begin
        sel_hit[k] = 1'b1;
        slot_ready = !out_valid[k] || out_ready[k];
      end
    end
  end

  assign sel_ok   = |sel_hit;
  assign in_ready = slot_ready;
  assign load     = (in_valid && slot_ready) ? sel_hit : '0;

  always_comb begin
    sel_err_d = in_valid && !sel_ok;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  assign sel_err = sel_err_q;

  for (genvar k = 0; k < N_CH; k++) begin : g_slot
    demux_stream_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .clk   (clk),
      .rst   (rst),
      .load  (load[k]),
      .din   (in_data),
      .ready (out_ready[k]),
      .valid (out_valid[k]),
      .dout  (out_data[k*DATA_W +: DATA_W]),
      .cnt   (xfer_cnt[k*DEMUX_CNT_W +: DEMUX_CNT_W])
    );
  end

endmodule : demux_stream

`default_nettype wire

// File: tb/tb_demux_stream.sv
// ============================================================================
// Module   : tb_demux_stream
// Brief    : Scoreboard bench for demux_stream; drives an 8-channel and a
//            6-channel instance in parallel (DEMUX_STREAM_CNT_EN aware).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_demux_stream;

  localparam int DW = 8;
  localparam int NA = 8;
  localparam int NB = 6;
`ifdef DEMUX_STREAM_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic [2:0]    in_sel;
  logic          in_valid;
  logic [15:0]   out_ready;
  logic [1:0]    in_ready;
  logic [1:0]    sel_err;

  logic [NA*DW-1:0] od_a;
  logic [NA-1:0]    ov_a;
  logic [NA*16-1:0] cnt_a;
  logic [NB*DW-1:0] od_b;
  logic [NB-1:0]    ov_b;
  logic [NB*16-1:0] cnt_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  demux_stream #(.DATA_W(DW), .N_CH(NA)) u_dut_a (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready[0]), .out_data(od_a), .out_valid(ov_a),
    .out_ready(out_ready[NA-1:0]), .sel_err(sel_err[0]), .xfer_cnt(cnt_a)
  );

  demux_stream #(.DATA_W(DW), .N_CH(NB)) u_dut_b (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready[1]), .out_data(od_b), .out_valid(ov_b),
    .out_ready(out_ready[NB-1:0]), .sel_err(sel_err[1]), .xfer_cnt(cnt_b)
  );

  // Uniform per-channel views of both instances.
  logic [15:0]   v_ov [2];
  logic [DW-1:0] v_od [2][16];
  logic [15:0]   v_oc [2][16];

  always_comb begin
    v_ov[0] = '0;
    v_ov[1] = '0;
    for (int k = 0; k < 16; k++) begin
      v_od[0][k] = '0; v_od[1][k] = '0;
      v_oc[0][k] = '0; v_oc[1][k] = '0;
    end
    for (int k = 0; k < NA; k++) begin
      v_ov[0][k] = ov_a[k];
      v_od[0][k] = od_a[k*DW +: DW];
      v_oc[0][k] = cnt_a[k*16 +: 16];
    end
    for (int k = 0; k < NB; k++) begin
      v_ov[1][k] = ov_b[k];
      v_od[1][k] = od_b[k*DW +: DW];
      v_oc[1][k] = cnt_b[k*16 +: 16];
    end
  end

  // Reference model: each channel is a FIFO of accepted-but-unconsumed words.
  logic [DW-1:0] exp_q [32][$];
  logic [15:0]   m_cnt [2][16];
  bit            m_err [2];

  function automatic int nch(input int d);
    return (d == 0) ? NA : NB;
  endfunction

  task automatic check(input string tag, input int d, input int k,
                       input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut=%0d ch=%0d actual=%0h required=%0h t=%0t",
               tag, d, k, act, exp, $time);
      if (failures >= 200) begin
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  endtask

  // Predictor: at each active edge, decide what the block accepts.
  initial begin
    for (int d = 0; d < 2; d++) begin
      m_err[d] = 1'b0;
      for (int k = 0; k < 16; k++) m_cnt[d][k] = '0;
    end
    forever begin
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
        bit in_rng;
        int qi;
        in_rng = int'(in_sel) < nch(d);
        qi     = d*16 + int'(in_sel);
        if (rst) begin
          for (int k = 0; k < 16; k++) begin
            exp_q[d*16+k].delete();
            m_cnt[d][k] = '0;
          end
          m_err[d] = 1'b0;
        end else begin
          m_err[d] = in_valid && !in_rng;
          if (in_valid && in_rng && exp_q[qi].size() == 0) begin
            exp_q[qi].push_back(in_data);
            if (m_cnt[d][in_sel] < 16'hFFFF) m_cnt[d][in_sel] = m_cnt[d][in_sel] + 16'd1;
          end
        end
      end
    end
  end

  // Monitor: compare outputs mid-cycle, retire words the consumer takes.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int d = 0; d < 2; d++) begin
          bit in_rng;
          bit exp_rdy;
          in_rng  = int'(in_sel) < nch(d);
          exp_rdy = !in_rng || exp_q[d*16+int'(in_sel)].size() == 0 || out_ready[in_sel];
          check("in_ready", d, int'(in_sel), in_ready[d], exp_rdy);
          check("sel_err", d, 0, sel_err[d], m_err[d]);
          for (int k = 0; k < nch(d); k++) begin
            bit full;
            full = exp_q[d*16+k].size() != 0;
            check("out_valid", d, k, v_ov[d][k], full);
            check("out_data", d, k, v_od[d][k], full ? exp_q[d*16+k][0] : '0);
            check("xfer_cnt", d, k, v_oc[d][k], CNT_EN ? m_cnt[d][k] : 16'd0);
            if (full && out_ready[k]) void'(exp_q[d*16+k].pop_front());
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b1;
    in_sel   = 3'($urandom);
    in_data  = 8'($urandom);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst      = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    logic [127:0] exp_cnt;
    rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_data = '0; out_ready = '0;

    // Reset with a word offered throughout
    do_reset();
    @(negedge clk);
    check("rst_valid", 0, 0, ov_a, 0);
    check("rst_data", 0, 0, od_a, 0);
    check("rst_cnt", 0, 0, cnt_a, 0);
    check("rst_valid", 1, 0, ov_b, 0);

    // Basic route to channel 3
    @(posedge clk); #1;
    in_sel = 3'd3; in_data = 8'hA5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("route_valid", 0, 3, ov_a, 8'b0000_1000);
    check("route_data", 0, 3, od_a, 64'h0000_0000_A500_0000);

    // Backpressure on a full slot, then load-on-consume
    @(posedge clk); #1;
    in_sel = 3'd3; in_data = 8'h5A; in_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("bp_ready", 0, 3, in_ready[0], 1'b0);
      check("bp_hold", 0, 3, od_a[31:24], 8'hA5);
      @(posedge clk); #1;
    end
    out_ready[3] = 1'b1;
    @(negedge clk);
    check("bp_release", 0, 3, in_ready[0], 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_stay_valid", 0, 3, ov_a[3], 1'b1);
    check("bp_new_data", 0, 3, od_a[31:24], 8'h5A);

    // Back-to-back streaming across all channels
    @(posedge clk); #1;
    out_ready = '1;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      in_sel = 3'(i % 8); in_data = 8'(i); in_valid = 1'b1;
      @(negedge clk);
      check("stream_ready", 0, i % 8, in_ready[0], 1'b1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    exp_cnt = '0;
    for (int k = 0; k < NA; k++) exp_cnt[k*16 +: 16] = CNT_EN ? 16'd2 : 16'd0;
    check("stream_cnt", 0, 0, cnt_a, exp_cnt);

    // Out-of-range select on the 6-channel instance
    @(posedge clk); #1;
    out_ready = '0;
    do_reset();
    in_sel = 3'd1; in_data = 8'h11; in_valid = 1'b1;
    @(posedge clk); #1;
    in_sel = 3'd7; in_data = 8'h77;
    @(negedge clk);
    check("badsel_ready", 1, 7, in_ready[1], 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("badsel_err", 1, 7, sel_err[1], 1'b1);
    check("badsel_valid", 1, 7, ov_b, 6'b00_0010);
    check("badsel_data", 1, 1, od_b, 48'h0000_0000_1100);
    check("badsel_cnt", 1, 1, cnt_b, CNT_EN ? 96'h1_0000 : 96'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("badsel_pulse", 1, 7, sel_err[1], 1'b0);

    // Random traffic with a reset in the middle
    @(posedge clk); #1;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        do_reset();
      end else begin
        in_valid  = ($urandom_range(0, 9) < 7);
        in_sel    = 3'($urandom);
        in_data   = 8'($urandom);
        out_ready = 16'($urandom);
        @(posedge clk); #1;
      end
    end

    // Counter saturation on channel 0
    in_valid  = 1'b0;
    out_ready = '1;
    do_reset();
    in_sel   = 3'd0;
    in_valid = 1'b1;
    repeat (65540) begin
      in_data = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("sat_cnt", 0, 0, cnt_a[15:0], CNT_EN ? 16'hFFFF : 16'h0000);
    check("sat_cnt", 1, 0, cnt_b[15:0], CNT_EN ? 16'hFFFF : 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900_000;
    failures++;
    $display("FAIL watchdog dut=0 ch=0 actual=timeout required=done t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_demux_stream

`default_nettype wire
